// File: rtl/riscv_pkg.sv
// Shared fetch-path types: FSM state enum, buffered entry struct and PC width/increment.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_INC
`define PC_INC 4
`endif

package riscv_pkg;

  localparam int XLEN = `XLEN;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(`PC_INC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bundle: instruction-memory request/response, branch redirect and decode handshake.
`ifndef XLEN
`define XLEN 32
`endif

interface instr_fetch_ctrl_if;

  logic             imem_req_o;
  logic [`XLEN-1:0] imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [`XLEN-1:0] imem_rdata_i;
  logic             branch_en_i;
  logic [`XLEN-1:0] branch_addr_i;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic [`XLEN-1:0] pc_o;
  logic [`XLEN-1:0] instr_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, pc_o, instr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_en_i, branch_addr_i,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, pc_o, instr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_en_i, branch_addr_i,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with flush; head entry read from registers.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is reset so the head entry reads as zero straight out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory access, buffered decode output,
// branch flush. Define IFC_PERF_CNT_EN to add the stall_cnt_o cycle counter.
module instr_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int               FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  instr_fetch_ctrl_if.master        bus
`ifdef IFC_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic            req;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_after_push;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign pop              = bus.instr_valid_o & bus.instr_ready_i;
  assign count_after_push = fifo_count + CW'(1) - CW'(pop);
  assign wr_entry         = '{pc: fetch_pc, instr: bus.imem_rdata_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.branch_en_i || !fifo_full) state_next = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (bus.imem_gnt_i) state_next = bus.branch_en_i ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid_i) begin
          if (bus.branch_en_i) begin
            state_next = REQ;
          end else begin
            push       = 1'b1;
            state_next = (count_after_push < CW'(FIFO_DEPTH)) ? REQ : IDLE;
          end
        end else if (bus.branch_en_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The in-flight response retires here even if a new redirect arrives with it.
        if (bus.imem_rvalid_i) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)              fetch_pc <= RESET_PC;
    else if (bus.branch_en_i) fetch_pc <= bus.branch_addr_i;
    else if (push)            fetch_pc <= fetch_pc + PC_INC;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .flush   (bus.branch_en_i),
    .wdata   (wr_entry),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc;
  assign bus.instr_valid_o = ~fifo_empty;
  assign bus.pc_o          = head.pc;
  assign bus.instr_o       = head.instr;

`ifdef IFC_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)                                    stall_cnt_o <= '0;
    else if (!bus.instr_valid_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized memory/decode run
// checked against a stream-level fetch model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_instr_fetch_ctrl;

  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic zw_pend;

  instr_fetch_ctrl_if bus ();

`ifdef IFC_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
`ifdef IFC_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[7:0], pc[31:8]} ^ 32'h0000_0013;
  endfunction

  // Drive one cycle of inputs (called at a negedge), return at the following negedge.
  task automatic step(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                      input logic br, input logic [31:0] baddr, input logic ready);
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rvalid;
    bus.imem_rdata_i  = rdata;
    bus.branch_en_i   = br;
    bus.branch_addr_i = baddr;
    bus.instr_ready_i = ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Zero-wait memory returning 32'h13: grant every request, answer the following cycle.
  task automatic zw_cycle(input logic ready);
    logic req_now;
    req_now = bus.imem_req_o;
    step(req_now, zw_pend, 32'h0000_0013, 1'b0, 32'h0, ready);
    zw_pend = req_now;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst               = 1'b1;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.branch_en_i   = 1'b0;
    bus.branch_addr_i = '0;
    bus.instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    zw_pend = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.imem_req_o !== 1'b0)
      begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req_o); end
    n_checks++; if (bus.instr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid_o); end
    n_checks++; if (bus.pc_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.pc_o); end
    n_checks++; if (bus.instr_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_instr: got %h expected 0", bus.instr_o); end
    n_checks++; if (bus.imem_addr_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr_o); end
`ifdef IFC_PERF_CNT_EN
    n_checks++; if (stall_cnt !== 32'h0)
      begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_latency();
    logic [31:0] addrs[$];
    int first_valid = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      zw_cycle(1'b1);
      if (bus.imem_req_o) addrs.push_back(bus.imem_addr_o);
      if (bus.instr_valid_o && first_valid == 0) begin
        first_valid = c;
        n_checks++; if (bus.pc_o !== 32'h0)
          begin n_fail++; $display("FAIL latency_pc: got %h expected 0", bus.pc_o); end
        n_checks++; if (bus.instr_o !== 32'h0000_0013)
          begin n_fail++; $display("FAIL latency_instr: got %h expected 13", bus.instr_o); end
      end
    end
    n_checks++; if (first_valid != 3)
      begin n_fail++; $display("FAIL latency_cycle: got %0d expected 3", first_valid); end
    n_checks++;
    if (addrs.size() < 3) begin
      n_fail++; $display("FAIL latency_addr_count: got %0d expected >=3", addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (addrs[i] !== 32'(i * 4)) begin
          n_fail++; $display("FAIL latency_addr%0d: got %h expected %h", i, addrs[i], 32'(i * 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      zw_cycle(1'b0);
      if (bus.imem_req_o) nreq++;
      if (c >= 6) begin
        n_checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b1)
          begin n_fail++; $display("FAIL bp_hold c%0d: got req=%b valid=%b expected req=0 valid=1",
                                   c, bus.imem_req_o, bus.instr_valid_o); end
        n_checks++; if (bus.pc_o !== 32'h0 || bus.instr_o !== 32'h13)
          begin n_fail++; $display("FAIL bp_head c%0d: got pc=%h instr=%h expected pc=0 instr=13",
                                   c, bus.pc_o, bus.instr_o); end
      end
    end
    n_checks++; if (nreq != 2)
      begin n_fail++; $display("FAIL bp_requests: got %0d expected 2", nreq); end
    zw_cycle(1'b1);
    n_checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h4)
      begin n_fail++; $display("FAIL bp_second: got valid=%b pc=%h expected valid=1 pc=4",
                               bus.instr_valid_o, bus.pc_o); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    n_checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL bw_drain: got req=%b valid=%b expected 0 0",
                               bus.imem_req_o, bus.instr_valid_o); end
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100)
      begin n_fail++; $display("FAIL bw_addr: got req=%b addr=%h expected req=1 addr=100",
                               bus.imem_req_o, bus.imem_addr_o); end
    n_checks++; if (bus.instr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL bw_stale: got valid=%b expected 0", bus.instr_valid_o); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0);
    n_checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h100 || bus.instr_o !== 32'h13)
      begin n_fail++; $display("FAIL bw_entry: got valid=%b pc=%h instr=%h expected 1 100 13",
                               bus.instr_valid_o, bus.pc_o, bus.instr_o); end
  endtask

  task automatic test_branch_rvalid();
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'hBAD0_0BAD, 1'b1, 32'h200, 1'b1);
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200)
      begin n_fail++; $display("FAIL br_addr: got req=%b addr=%h expected req=1 addr=200",
                               bus.imem_req_o, bus.imem_addr_o); end
    n_checks++; if (bus.instr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL br_dropped: got valid=%b expected 0", bus.instr_valid_o); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0);
    n_checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h200 || bus.instr_o !== 32'h13)
      begin n_fail++; $display("FAIL br_entry: got valid=%b pc=%h instr=%h expected 1 200 13",
                               bus.instr_valid_o, bus.pc_o, bus.instr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    n_checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL rm_idle: got req=%b valid=%b expected 0 0",
                               bus.imem_req_o, bus.instr_valid_o); end
    step(1'b0, 1'b1, 32'hBAD0_0BAD, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.instr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL rm_stray: got valid=%b expected 0", bus.instr_valid_o); end
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0)
      begin n_fail++; $display("FAIL rm_req: got req=%b addr=%h expected req=1 addr=0",
                               bus.imem_req_o, bus.imem_addr_o); end
  endtask

`ifdef IFC_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [31:0] s0;
    do_reset();
    s0 = stall_cnt;
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (stall_cnt !== s0 + 32'd10)
      begin n_fail++; $display("FAIL perf_stall: got %0d expected %0d", stall_cnt, s0 + 32'd10); end
  endtask
`endif

  task automatic test_random();
    int          occ = 0;
    int          occ_pre;
    int          pops = 0;
    int          dly = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] fetch_m = 32'h0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] target;
    logic [31:0] rdata;
    logic        pending = 1'b0;
    logic        stale = 1'b0;
    logic        br, rdy, gnt, rv, req;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      req     = bus.imem_req_o;
      occ_pre = occ;
      n_checks++; if (bus.instr_valid_o !== (occ != 0))
        begin n_fail++; $display("FAIL rnd_valid cyc%0d: got %b expected %b",
                                 cyc, bus.instr_valid_o, occ != 0); end
      if (req) begin
        n_checks++; if (bus.imem_addr_o !== fetch_m)
          begin n_fail++; $display("FAIL rnd_addr cyc%0d: got %h expected %h",
                                   cyc, bus.imem_addr_o, fetch_m); end
        n_checks++; if (pending)
          begin n_fail++; $display("FAIL rnd_outstanding cyc%0d: got request with %0d pending expected 0",
                                   cyc, pending); end
      end
      br     = ($urandom_range(0, 99) < 4);
      target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      rdy    = br ? 1'b0 : ($urandom_range(0, 3) != 0);
      gnt    = req && ($urandom_range(0, 2) != 0);
      rv     = pending && (dly == 0);
      rdata  = rv ? instr_of(pend_addr) : $urandom();
      if (bus.instr_valid_o && rdy) begin
        n_checks++; if (bus.pc_o !== exp_pc)
          begin n_fail++; $display("FAIL rnd_pc cyc%0d: got %h expected %h", cyc, bus.pc_o, exp_pc); end
        n_checks++; if (bus.instr_o !== instr_of(exp_pc))
          begin n_fail++; $display("FAIL rnd_instr cyc%0d: got %h expected %h",
                                   cyc, bus.instr_o, instr_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        if (occ > 0) occ--;
        pops++;
      end
      if (rv) begin
        pending = 1'b0;
        if (!stale && !br) begin
          n_checks++; if (occ_pre >= DEPTH)
            begin n_fail++; $display("FAIL rnd_overflow cyc%0d: got occupancy %0d expected <%0d",
                                     cyc, occ_pre, DEPTH); end
          occ++;
          fetch_m = fetch_m + 32'd4;
        end
      end else if (pending) begin
        dly--;
      end
      if (gnt) begin
        pending   = 1'b1;
        stale     = 1'b0;
        pend_addr = bus.imem_addr_o;
        dly       = $urandom_range(0, 3);
      end
      if (br) begin
        occ     = 0;
        exp_pc  = target;
        fetch_m = target;
        if (pending) stale = 1'b1;
      end
      step(gnt, rv, rdata, br, target, rdy);
    end
    n_checks++; if (pops < 200)
      begin n_fail++; $display("FAIL rnd_progress: got %0d pops expected >=200", pops); end
  endtask

  initial begin
    rst = 1'b1;
    zw_pend = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_branch_wait();
    test_branch_rvalid();
    test_reset_mid();
`ifdef IFC_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
